floating_point_scale_scheduler: RTL and testbench

Round-robin scheduler that shares one pipelined floating-point scale unit (multiply by a fixed power of two, or by zero) between `NUM_REQ` requesters. It arbitrates valid/ready requests, issues at most one operand per cycle to the unit, and tracks which requester owns each in-flight result. Results are buffered in order in a result FIFO and returned on one tagged valid/ready output. Issue is credit-gated, so the non-stallable unit never overflows the FIFO.

---
 rtl/floating_point_scale_scheduler_if.sv | 35 +++
 rtl/floating_point_scale_scheduler.sv | 173 +++++++++++++++++
 tb/tb_floating_point_scale_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/floating_point_scale_scheduler_if.sv
// Handshake bundle between the scale scheduler, its requesters, the shared scale unit
// and the downstream result consumer.
interface floating_point_scale_scheduler_if #(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 23,
  parameter int unsigned NUM_REQ    = 4
);
  localparam int unsigned FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int unsigned TAG_W    = $clog2(NUM_REQ);

  logic [NUM_REQ*FP_WIDTH-1:0] req_fp_i;
  logic [NUM_REQ-1:0]          req_valid_i;
  logic [NUM_REQ-1:0]          req_ready_o;
  logic [FP_WIDTH-1:0]         unit_fp_o;
  logic                        unit_valid_o;
  logic [FP_WIDTH-1:0]         unit_fp_i;
  logic                        unit_valid_i;
  logic [FP_WIDTH-1:0]         fp_o;
  logic [TAG_W-1:0]            tag_o;
  logic                        valid_o;
  logic                        ready_i;
  logic                        error_o;

  // Scheduler side.
  modport slave (
    input  req_fp_i, req_valid_i, unit_fp_i, unit_valid_i, ready_i,
    output req_ready_o, unit_fp_o, unit_valid_o, fp_o, tag_o, valid_o, error_o
  );

  // Environment side: requesters, scale unit and result consumer.
  modport master (
    output req_fp_i, req_valid_i, unit_fp_i, unit_valid_i, ready_i,
    input  req_ready_o, unit_fp_o, unit_valid_o, fp_o, tag_o, valid_o, error_o
  );
endinterface

// File: rtl/floating_point_scale_scheduler.sv
// Round-robin, credit-gated scheduler sharing one pipelined FP scale unit among NUM_REQ
// requesters; results are returned in issue order with the owning requester's tag.
module floating_point_scale_scheduler #(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 23,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                            clk_i,
  input logic                            rst_ni,
  floating_point_scale_scheduler_if.slave bus
);

  localparam int unsigned FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int unsigned TAG_W    = $clog2(NUM_REQ);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned ENTRY_W  = TAG_W + FP_WIDTH;

  if (NUM_REQ < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LATENCY < 1)
  begin : g_bad_cfg
    $error("floating_point_scale_scheduler: invalid parameter configuration");
  end

  // Registered state
  logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;
  logic [FP_WIDTH-1:0] unit_fp_q, unit_fp_d;
  logic                unit_valid_q, unit_valid_d;
  logic                error_q, error_d;
  logic [PTR_W:0]      tq_wr_q, tq_wr_d, tq_rd_q, tq_rd_d;
  logic [PTR_W:0]      res_wr_q, res_wr_d, res_rd_q, res_rd_d;

  logic [TAG_W-1:0]    tq_mem_q  [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  res_mem_q [FIFO_DEPTH];

  // Combinational signals
  logic [CNT_W:0]      used;
  logic                issue_ok;
  logic                grant;
  logic [TAG_W-1:0]    gnt_idx;
  logic [TAG_W-1:0]    cand;
  logic [NUM_REQ-1:0]  req_ready;
  logic [FP_WIDTH-1:0] sel_fp;
  logic                tq_empty;
  logic [TAG_W-1:0]    tq_head;
  logic                ret_ok, ret_err;
  logic                res_push, res_pop, res_full;
  logic                valid;

  // Credits count both buffered and in-flight results so the unit can never overrun the FIFO.
  always_comb begin
    used     = {1'b0, fifo_count_q} + {1'b0, inflight_q};
    issue_ok = used < (CNT_W + 1)'(FIFO_DEPTH);
  end

  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (issue_ok) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = TAG_W'((32'(rr_ptr_q) + i) % NUM_REQ);
        if (!grant && bus.req_valid_i[cand]) begin
          grant   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_fp    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant && TAG_W'(k) == gnt_idx) begin
        req_ready[k] = 1'b1;
        sel_fp       = bus.req_fp_i[k*FP_WIDTH +: FP_WIDTH];
      end
    end
  end

  always_comb begin
    tq_empty = (tq_wr_q == tq_rd_q);
    tq_head  = tq_mem_q[tq_rd_q[PTR_W-1:0]];
    ret_ok   = bus.unit_valid_i && !tq_empty;
    ret_err  = bus.unit_valid_i && tq_empty;
    valid    = (fifo_count_q != '0);
    res_push = ret_ok;
    res_pop  = valid && bus.ready_i;
    res_full = (res_wr_q[PTR_W] != res_rd_q[PTR_W]) &&
               (res_wr_q[PTR_W-1:0] == res_rd_q[PTR_W-1:0]);
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    inflight_d   = inflight_q;
    fifo_count_d = fifo_count_q;
    unit_fp_d    = unit_fp_q;
    unit_valid_d = grant;
    error_d      = error_q | ret_err;
    tq_wr_d      = tq_wr_q + (PTR_W + 1)'(grant);
    tq_rd_d      = tq_rd_q + (PTR_W + 1)'(ret_ok);
    res_wr_d     = res_wr_q + (PTR_W + 1)'(res_push);
    res_rd_d     = res_rd_q + (PTR_W + 1)'(res_pop);

    if (grant) begin
      unit_fp_d = sel_fp;
      rr_ptr_d  = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
    end

    unique case ({grant, ret_ok})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    unique case ({res_push, res_pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      unit_fp_q    <= '0;
      unit_valid_q <= 1'b0;
      error_q      <= 1'b0;
      tq_wr_q      <= '0;
      tq_rd_q      <= '0;
      res_wr_q     <= '0;
      res_rd_q     <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      unit_fp_q    <= unit_fp_d;
      unit_valid_q <= unit_valid_d;
      error_q      <= error_d;
      tq_wr_q      <= tq_wr_d;
      tq_rd_q      <= tq_rd_d;
      res_wr_q     <= res_wr_d;
      res_rd_q     <= res_rd_d;
    end
  end

  // Storage needs no reset: entries are only read once their pointers mark them valid.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      tq_mem_q[tq_wr_q[PTR_W-1:0]] <= gnt_idx;
    end
    if (res_push) begin
      res_mem_q[res_wr_q[PTR_W-1:0]] <= {tq_head, bus.unit_fp_i};
    end
  end

  assign bus.req_ready_o            = req_ready;
  assign bus.unit_fp_o              = unit_fp_q;
  assign bus.unit_valid_o           = unit_valid_q;
  assign bus.valid_o                = valid;
  assign bus.error_o                = error_q;
  assign {bus.tag_o, bus.fp_o}      = valid ? res_mem_q[res_rd_q[PTR_W-1:0]] : '0;

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(res_push && res_full));

endmodule

// File: tb/tb_floating_point_scale_scheduler.sv
// Scoreboard bench: directed requests push expected {tag, result}; a monitor pops and
// compares whenever the scheduler hands a result downstream.
module tb_floating_point_scale_scheduler;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned LATENCY    = 1;
  localparam int unsigned FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inject = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q [$];
  logic [31:0] ops  [4];
  logic [31:0] res4 [4];

  always #5 clk = ~clk;

  floating_point_scale_scheduler_if #(
    .EXP_WIDTH (8),
    .FRAC_WIDTH(23),
    .NUM_REQ   (NUM_REQ)
  ) bus ();

  floating_point_scale_scheduler #(
    .EXP_WIDTH (8),
    .FRAC_WIDTH(23),
    .NUM_REQ   (NUM_REQ),
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Shared unit model: multiply by 4 (exponent + 2), LATENCY register stages.
  function automatic logic [31:0] scale4(input logic [31:0] f);
    return {f[31], f[30:23] + 8'd2, f[22:0]};
  endfunction

  logic [31:0]        pipe_fp [LATENCY];
  logic [LATENCY-1:0] pipe_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_fp[i] <= '0;
    end else begin
      pipe_v[0]  <= bus.unit_valid_o;
      pipe_fp[0] <= scale4(bus.unit_fp_o);
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_fp[i] <= pipe_fp[i-1];
      end
    end
  end

  assign bus.unit_valid_i = pipe_v[LATENCY-1] | inject;
  assign bus.unit_fp_i    = pipe_fp[LATENCY-1];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_unexpected: got tag=%0d fp=%h, required no output",
                 bus.tag_o, bus.fp_o);
      end else begin
        check_eq("scoreboard_result", 64'({bus.tag_o, bus.fp_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    bus.req_fp_i    = '0;
    bus.ready_i     = 1'b1;
    inject          = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    bus.req_valid_i = '0;
    bus.ready_i     = 1'b1;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    @(negedge clk);
    check_eq("drained_valid", 64'(bus.valid_o), 64'd0);
  endtask

  task automatic scen_single();
    tick();
    bus.ready_i     = 1'b1;
    bus.req_fp_i    = {32'h0, 32'h3F800000, 64'h0};
    bus.req_valid_i = 4'b0100;
    exp_q.push_back({2'd2, 32'h40800000});
    @(negedge clk);
    check_eq("single_grant", 64'(bus.req_ready_o), 64'h4);
    tick();
    bus.req_valid_i = '0;
    @(negedge clk);
    check_eq("single_unit_valid", 64'(bus.unit_valid_o), 64'd1);
    check_eq("single_unit_fp", 64'(bus.unit_fp_o), 64'h3F800000);
    tick();
    @(negedge clk);
    check_eq("single_valid_t2", 64'(bus.valid_o), 64'd0);
    tick();
    @(negedge clk);
    check_eq("single_valid_t3", 64'(bus.valid_o), 64'd1);
    drain(20);
  endtask

  initial begin
    ops[0]  = 32'h3F800000;  res4[0] = 32'h40800000;  //  1.0 ->  4.0
    ops[1]  = 32'h40000000;  res4[1] = 32'h41000000;  //  2.0 ->  8.0
    ops[2]  = 32'hC0400000;  res4[2] = 32'hC1400000;  // -3.0 -> -12.0
    ops[3]  = 32'h42280000;  res4[3] = 32'h43280000;  // 42.0 -> 168.0
    bus.req_valid_i = '0;
    bus.req_fp_i    = '0;
    bus.ready_i     = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_req_ready", 64'(bus.req_ready_o), 64'd0);
    check_eq("reset_unit_valid", 64'(bus.unit_valid_o), 64'd0);
    check_eq("reset_unit_fp", 64'(bus.unit_fp_o), 64'd0);
    check_eq("reset_valid", 64'(bus.valid_o), 64'd0);
    check_eq("reset_fp", 64'(bus.fp_o), 64'd0);
    check_eq("reset_tag", 64'(bus.tag_o), 64'd0);
    check_eq("reset_error", 64'(bus.error_o), 64'd0);

    scen_single();

    // All four valid from rr_ptr=0: grants rotate 0,1,2,3,0,...
    do_reset();
    bus.req_fp_i    = {ops[3], ops[2], ops[1], ops[0]};
    bus.req_valid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({2'(i % 4), res4[i % 4]});
      @(negedge clk);
      check_eq("rr_grant", 64'(bus.req_ready_o), 64'd1 << (i % 4));
      tick();
    end
    drain(30);

    // Credit exhaustion with downstream stalled.
    do_reset();
    bus.ready_i     = 1'b0;
    bus.req_fp_i    = {ops[3], ops[2], ops[1], ops[0]};
    bus.req_valid_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'(i), res4[i]});
      @(negedge clk);
      check_eq("credit_grant", 64'(bus.req_ready_o), 64'd1 << i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("credit_blocked", 64'(bus.req_ready_o), 64'd0);
      tick();
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    check_eq("credit_pop_not_comb", 64'(bus.req_ready_o), 64'd0);
    tick();
    bus.ready_i = 1'b0;
    exp_q.push_back({2'd0, res4[0]});
    @(negedge clk);
    check_eq("credit_one_grant", 64'(bus.req_ready_o), 64'd1);
    tick();
    @(negedge clk);
    check_eq("credit_blocked_again", 64'(bus.req_ready_o), 64'd0);
    tick();
    drain(30);

    // Requesters 1 and 3 with rr_ptr=2: grant 3, then wrap to 1.
    do_reset();
    bus.req_fp_i    = {ops[3], ops[2], ops[1], ops[0]};
    bus.req_valid_i = 4'b0010;
    exp_q.push_back({2'd1, res4[1]});
    @(negedge clk);
    check_eq("skip_setup_grant1", 64'(bus.req_ready_o), 64'h2);
    tick();
    bus.req_valid_i = 4'b1010;
    exp_q.push_back({2'd3, res4[3]});
    @(negedge clk);
    check_eq("skip_grant3", 64'(bus.req_ready_o), 64'h8);
    tick();
    bus.req_valid_i = 4'b0010;
    exp_q.push_back({2'd1, res4[1]});
    @(negedge clk);
    check_eq("skip_wrap_grant1", 64'(bus.req_ready_o), 64'h2);
    tick();
    drain(30);

    // Unit result with nothing issued.
    do_reset();
    inject = 1'b1;
    @(negedge clk);
    check_eq("err_not_yet", 64'(bus.error_o), 64'd0);
    tick();
    inject = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("err_sticky", 64'(bus.error_o), 64'd1);
      check_eq("err_no_valid", 64'(bus.valid_o), 64'd0);
      tick();
    end
    do_reset();
    @(negedge clk);
    check_eq("err_cleared", 64'(bus.error_o), 64'd0);
    tick();

    // Asynchronous reset with 2 results buffered and 1 in flight.
    do_reset();
    bus.ready_i     = 1'b0;
    bus.req_fp_i    = {ops[3], ops[2], ops[1], ops[0]};
    bus.req_valid_i = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'(i), res4[i]});
      @(negedge clk);
      check_eq("async_grant", 64'(bus.req_ready_o), 64'd1 << i);
      tick();
    end
    bus.req_valid_i = '0;
    tick();
    check_eq("async_buffered", 64'(bus.valid_o), 64'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("async_valid", 64'(bus.valid_o), 64'd0);
    check_eq("async_fp", 64'(bus.fp_o), 64'd0);
    check_eq("async_tag", 64'(bus.tag_o), 64'd0);
    check_eq("async_unit_valid", 64'(bus.unit_valid_o), 64'd0);
    check_eq("async_unit_fp", 64'(bus.unit_fp_o), 64'd0);
    check_eq("async_error", 64'(bus.error_o), 64'd0);
    check_eq("async_req_ready", 64'(bus.req_ready_o), 64'd0);
    bus.ready_i = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    scen_single();

    check_eq("final_error", 64'(bus.error_o), 64'd0);
    check_eq("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
